// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code sweep controller.
package gray_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Gray encoding of a binary value (callers truncate to their width).
  function automatic logic [31:0] bin2gray(input logic [31:0] value);
    return value ^ (value >> 1);
  endfunction

  // Number of set bits.
  function automatic int unsigned popcount(input logic [31:0] value);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (value[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/gray_sweep_ctrl_if.sv
// Valid/ready stream carrying the emitted Gray codes.
interface gray_sweep_ctrl_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] gray_out;
  logic             out_valid;
  logic             out_ready;

  modport master (output gray_out, output out_valid, input  out_ready);
  modport slave  (input  gray_out, input  out_valid, output out_ready);
endinterface

// File: rtl/binary_to_gray.sv
// Combinational binary to Gray converter.
module binary_to_gray
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = WIDTH'(bin2gray(32'(bin)));

endmodule

// File: rtl/gray_sweep_ctrl.sv
// Sweeps a binary counter over a programmed range and streams the Gray codes,
// flagging any pair of consecutive accepted codes that is not one bit apart.
module gray_sweep_ctrl
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] start_val,
  input  logic [WIDTH-1:0] end_val,
  input  logic             abort,
  gray_sweep_ctrl_if.master st,
  output logic             busy,
  output logic             done,
  output logic             seq_err
);

  state_t           r_state;
  logic             r_dir;
  logic [WIDTH-1:0] r_end;
  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic [WIDTH-1:0] r_last_gray;
  logic             r_first;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_seq_err;

  logic [WIDTH-1:0] w_next_bin;
  logic [WIDTH-1:0] w_next_gray;
  logic             w_handshake;

  assign w_handshake = r_valid & st.out_ready;

  // Next binary count: the load value while idle, otherwise one step in the
  // latched direction; sharing one converter covers both the load and step.
  always_comb begin
    w_next_bin = start_val;
    if (r_state != IDLE) begin
      w_next_bin = r_dir ? (r_bin - WIDTH'(1)) : (r_bin + WIDTH'(1));
    end
  end

  binary_to_gray #(.WIDTH(WIDTH)) u_b2g (
    .bin  (w_next_bin),
    .gray (w_next_gray)
  );

  // Sweep FSM with registered stream outputs and the adjacency monitor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_dir       <= 1'b0;
      r_end       <= '0;
      r_bin       <= '0;
      r_gray      <= '0;
      r_last_gray <= '0;
      r_first     <= 1'b1;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_seq_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_handshake) begin
        if (!r_first && (popcount(32'(r_gray ^ r_last_gray)) != 1)) begin
          r_seq_err <= 1'b1;
        end
        r_last_gray <= r_gray;
        r_first     <= 1'b0;
      end

      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_dir   <= dir;
            r_end   <= end_val;
            r_bin   <= start_val;
            r_gray  <= w_next_gray;
            r_first <= 1'b1;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          // Abort takes priority over completion; the element handshaken in
          // the abort cycle is still counted by the monitor above.
          if (abort) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (w_handshake) begin
            if (r_bin == r_end) begin
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_bin  <= w_next_bin;
              r_gray <= w_next_gray;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign st.gray_out  = r_gray;
  assign st.out_valid = r_valid;
  assign busy         = r_busy;
  assign done         = r_done;
  assign seq_err      = r_seq_err;

endmodule

// File: tb/tb_gray_sweep_ctrl.sv
// Scoreboard bench for gray_sweep_ctrl: sweeps are modelled from the range
// rules and a reflected-table Gray sequence, a negedge monitor pops/compares.
module tb_gray_sweep_ctrl;
  localparam int unsigned W = 4;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         dir = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] start_val = '0;
  logic [W-1:0] end_val = '0;
  logic         busy, done, seq_err;

  gray_sweep_ctrl_if #(.WIDTH(W)) st ();

  gray_sweep_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dir       (dir),
    .start_val (start_val),
    .end_val   (end_val),
    .abort     (abort),
    .st        (st),
    .busy      (busy),
    .done      (done),
    .seq_err   (seq_err)
  );

  always #5 clk = ~clk;

  int           n_tests = 0;
  int           n_fail = 0;
  int           gtab [M];
  logic [W-1:0] exp_q [$];
  int           exp_done = 0;
  int           got_done = 0;
  logic         prev_done = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reflected construction of the Gray sequence, indexed by binary value.
  task automatic build_table();
    gtab[0] = 0;
    for (int k = 0; k < int'(W); k++) begin
      int n;
      n = 1 << k;
      for (int i = 0; i < n; i++) gtab[n + i] = gtab[n - 1 - i] | n;
    end
  endtask

  task automatic push_sweep(input int s, input int e, input bit d, input bit fake,
                            input logic [W-1:0] fval);
    int len;
    int b;
    len = d ? (((s - e) % M + M) % M) + 1 : (((e - s) % M + M) % M) + 1;
    for (int k = 0; k < len; k++) begin
      b = (((d ? s - k : s + k) % M) + M) % M;
      exp_q.push_back(fake ? fval : W'(gtab[b]));
    end
  endtask

  task automatic start_sweep(input int s, input int e, input bit d, input bit fake,
                             input logic [W-1:0] fval);
    push_sweep(s, e, d, fake, fval);
    exp_done++;
    start     = 1'b1;
    start_val = W'(s);
    end_val   = W'(e);
    dir       = d;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_latency_valid", 32'(st.out_valid), 1);
    chk("start_busy", 32'(busy), 1);
  endtask

  task automatic wait_idle(input int budget, input bit rand_ready, output int c);
    c = 0;
    while ((exp_q.size() != 0 || busy || done) && c < budget) begin
      @(posedge clk); #1;
      st.out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      c++;
    end
    if (c >= budget) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_idle: timeout after %0d cycles, %0d elements pending", c, exp_q.size());
    end
  endtask

  // Monitor: compare each presented element, and check done pulses.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done <= 1'b0;
    end else begin
      if (st.out_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_elem: got %0h expected none", st.gray_out);
        end else if (st.out_ready) begin
          chk("elem", 32'(st.gray_out), 32'(exp_q.pop_front()));
        end else begin
          chk("stall_hold", 32'(st.gray_out), 32'(exp_q[0]));
        end
      end
      if (done) begin
        got_done++;
        chk("done_after_last", 32'(exp_q.size()), 0);
        chk("done_single_cycle", 32'(prev_done), 0);
      end
      prev_done <= done;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    st.out_ready = 1'b0;
    build_table();

    // Reset state
    #12;
    chk("rst_gray", 32'(st.gray_out), 0);
    chk("rst_valid", 32'(st.out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_seq_err", 32'(seq_err), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 0..3 up, back to back: 4 accepts then the done cycle
    st.out_ready = 1'b1;
    start_sweep(0, 3, 1'b0, 1'b0, '0);
    wait_idle(100, 1'b0, c);
    chk("t1_cycles", 32'(c), 5);
    chk("t1_seq_err", 32'(seq_err), 0);

    // Wrap-around 14..1 up
    start_sweep(14, 1, 1'b0, 1'b0, '0);
    wait_idle(100, 1'b0, c);
    chk("t2_cycles", 32'(c), 5);

    // 5..2 down with a 3-cycle stall after the second element
    start_sweep(5, 2, 1'b1, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1 st.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", 32'(st.out_valid), 1);
    end
    st.out_ready = 1'b1;
    wait_idle(100, 1'b0, c);

    // Single element 7..7; start pulses in RUN and DONE are ignored
    st.out_ready = 1'b0;
    start_sweep(7, 7, 1'b0, 1'b0, '0);
    start = 1'b1; start_val = W'(0); end_val = W'(3); dir = 1'b0;
    @(posedge clk); #1;
    st.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("single_done", 32'(done), 1);
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_in_done_ignored", 32'(st.out_valid), 0);
    wait_idle(100, 1'b0, c);

    // Abort after the second accept of 0..15; abort-cycle accept completes
    start_sweep(0, 15, 1'b0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_valid_low", 32'(st.out_valid), 0);
    chk("abort_busy_low", 32'(busy), 0);
    chk("abort_accepted_three", 32'(exp_q.size()), 13);
    exp_q.delete();
    exp_done--;
    repeat (3) @(posedge clk);
    #1 chk("abort_no_done", 32'(got_done), 32'(exp_done));
    start_sweep(0, 1, 1'b0, 1'b0, '0);
    wait_idle(100, 1'b0, c);
    chk("after_abort_seq_err", 32'(seq_err), 0);

    // Random sweeps with random back-pressure
    for (int t = 0; t < 24; t++) begin
      start_sweep(int'($urandom_range(0, M - 1)), int'($urandom_range(0, M - 1)),
                  1'($urandom_range(0, 1)), 1'b0, '0);
      wait_idle(400, 1'b1, c);
      st.out_ready = 1'b1;
    end
    chk("random_seq_err", 32'(seq_err), 0);

    // Asynchronous reset mid-sweep
    start_sweep(0, 15, 1'b0, 1'b0, '0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_gray", 32'(st.gray_out), 0);
    chk("midrst_valid", 32'(st.out_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    exp_q.delete();
    exp_done--;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Non-adjacent codes forced onto the converter output set seq_err
    force dut.w_next_gray = 4'h6;
    start_sweep(0, 2, 1'b0, 1'b1, 4'h6);
    wait_idle(100, 1'b0, c);
    release dut.w_next_gray;
    chk("fault_seq_err_set", 32'(seq_err), 1);
    start_sweep(3, 5, 1'b0, 1'b0, '0);
    wait_idle(100, 1'b0, c);
    chk("fault_seq_err_sticky", 32'(seq_err), 1);
    rst_n = 1'b0;
    #1 chk("fault_seq_err_cleared", 32'(seq_err), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    chk("final_queue_empty", 32'(exp_q.size()), 0);
    chk("final_done_count", 32'(got_done), 32'(exp_done));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
